// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port responder: decodes 3-byte I2C write frames addressed to
// DEV_ADDR, acks them, and maintains the codec's 10x9-bit register file.
// The bus is open-drain: this block only ever pulls SDA low via sda_oe.
//
// Handshake: reg_wr_valid is a single-clk strobe with no ready; reg_wr_addr
// and reg_wr_data are valid while it is high and hold until the next commit.
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_p, sda_p;
  logic                   scl_s, sda_s;
  logic [2:0]             cnt;
  logic [7:0]             shreg;
  logic [7:0]             byte1;
  logic [8:0]             regs [10];

  function automatic logic [8:0] reg_default(input int idx);
    case (idx)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      7:       return 9'h00A;
      default: return 9'h000;
    endcase
  endfunction

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // Bus conditions derived from the synchronised lines and their previous values
  logic       start_det, stop_det, scl_rise, scl_fall;
  logic [7:0] next_byte;
  assign start_det = scl_s & sda_p & ~sda_s;
  assign stop_det  = scl_s & ~sda_p & sda_s;
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign next_byte = {shreg[6:0], sda_s};

  // Synchronisers reset to the idle-bus level so reset release never fakes an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  // Frame FSM, ack driver, commit strobe and register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      shreg        <= 8'h00;
      byte1        <= 8'h00;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 7'h00;
      reg_wr_data  <= 9'h000;
      for (int i = 0; i < 10; i++) regs[i] <= reg_default(i);
    end else begin
      reg_wr_valid <= 1'b0;
      if (start_det) begin
        state  <= ADDR;
        cnt    <= 3'd0;
        busy   <= 1'b1;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        cnt    <= 3'd0;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          ADDR, BYTE1, BYTE2: begin
            if (scl_rise) begin
              shreg <= next_byte;
              cnt   <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (state == ADDR) begin
                  // Only a write to our address is acked; reads are never answered
                  if (next_byte[7:1] == DEV_ADDR && !next_byte[0]) state <= ACK_A;
                  else                                           state <= IGNORE;
                end else if (state == BYTE1) begin
                  byte1 <= next_byte;
                  state <= ACK_1;
                end else begin
                  state <= ACK_2;
                end
              end
            end
          end
          ACK_A, ACK_1, ACK_2: begin
            // First falling edge starts the ack bit, the second one ends it
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                cnt    <= 3'd0;
                case (state)
                  ACK_A:   state <= BYTE1;
                  ACK_1:   state <= BYTE2;
                  default: state <= IGNORE;
                endcase
              end
            end else if (scl_rise && sda_oe && state == ACK_2) begin
              reg_wr_valid <= 1'b1;
              reg_wr_addr  <= byte1[7:1];
              reg_wr_data  <= {byte1[0], shreg};
              if (byte1[7:1] == 7'h0F) begin
                for (int i = 0; i < 10; i++) regs[i] <= reg_default(i);
              end else begin
                for (int i = 0; i < 10; i++)
                  if (byte1[7:1] == 7'(i)) regs[i] <= {byte1[0], shreg};
              end
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

  // Combinational register read; out-of-range indices read as zero
  always_comb begin
    rd_data = 9'h000;
    for (int i = 0; i < 10; i++)
      if (rd_addr == 4'(i)) rd_data = regs[i];
  end

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench for wm8731_i2c_responder: a bit-banged I2C master on an
// open-drain SDA line, a table of write frames, and hand-written sequences
// for stop/repeated-start/reset corner cases.
module tb_wm8731_i2c_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, reg_wr_valid, busy;
  logic [6:0] reg_wr_addr;
  logic [8:0] reg_wr_data;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int dbl_cnt   = 0;
  logic last_v  = 1'b0;
  logic oe_seen = 1'b0;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  wm8731_i2c_responder dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts commit pulses, back-to-back highs, and any SDA pull
  always @(posedge clk) begin
    #1;
    if (reg_wr_valid) pulse_cnt++;
    if (reg_wr_valid && last_v) dbl_cnt++;
    last_v = reg_wr_valid;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(4);
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(4);
    scl_m = 1'b1; wait_clk(4);
    sda_m = 1'b1; wait_clk(4);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(4);
    scl_m = 1'b1; wait_clk(8);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(4);
    ack = sda_oe;
    wait_clk(4);
    scl_m = 1'b0; wait_clk(4);
  endtask

  task automatic check_reg(input string name, input logic [3:0] idx, input logic [8:0] exp);
    rd_addr = idx;
    #1;
    check(name, 32'(rd_data), 32'(exp));
  endtask

  typedef struct {
    logic [7:0] a, b1, b2;
    logic [2:0] acks;
    logic       pulse;
    logic [6:0] waddr;
    logic [8:0] wdata;
    logic [3:0] ridx;
    logic [8:0] rexp;
  } vec_t;

  vec_t vecs[8];

  logic [8:0] defaults [10];

  initial begin
    logic ack, ack0, ack1, ack2;
    int   p0;

    defaults = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
    //          addr   b1     b2     acks    pulse waddr  wdata   ridx  rexp
    vecs[0] = '{8'h34, 8'h08, 8'h12, 3'b111, 1'b1, 7'h04, 9'h012, 4'd4,  9'h012};
    vecs[1] = '{8'h36, 8'h08, 8'h55, 3'b000, 1'b0, 7'h00, 9'h000, 4'd4,  9'h012};
    vecs[2] = '{8'h35, 8'h0C, 8'h99, 3'b000, 1'b0, 7'h00, 9'h000, 4'd6,  9'h09F};
    vecs[3] = '{8'h34, 8'h13, 8'hFF, 3'b111, 1'b1, 7'h09, 9'h1FF, 4'd9,  9'h1FF};
    vecs[4] = '{8'h34, 8'h40, 8'hAA, 3'b111, 1'b1, 7'h20, 9'h0AA, 4'd0,  9'h097};
    vecs[5] = '{8'h34, 8'h0C, 8'h00, 3'b111, 1'b1, 7'h06, 9'h000, 4'd6,  9'h000};
    vecs[6] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1'b1, 7'h0F, 9'h000, 4'd6,  9'h09F};
    vecs[7] = '{8'h34, 8'h15, 8'h77, 3'b111, 1'b1, 7'h0A, 9'h177, 4'd10, 9'h000};

    // Reset state
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(reg_wr_valid), 32'd0);
    check("rst_waddr", 32'(reg_wr_addr), 32'd0);
    check("rst_wdata", 32'(reg_wr_data), 32'd0);
    for (int i = 0; i < 10; i++) check_reg($sformatf("rst_reg%0d", i), 4'(i), defaults[i]);
    check_reg("rst_reg15", 4'd15, 9'h000);

    // Table of complete frames
    for (int i = 0; i < 8; i++) begin
      p0 = pulse_cnt;
      oe_seen = 1'b0;
      i2c_start();
      check($sformatf("v%0d_busy_start", i), 32'(busy), 32'd1);
      send_byte(vecs[i].a,  ack0);
      send_byte(vecs[i].b1, ack1);
      send_byte(vecs[i].b2, ack2);
      check($sformatf("v%0d_acks", i), 32'({ack0, ack1, ack2}), 32'(vecs[i].acks));
      check($sformatf("v%0d_busy_pre_stop", i), 32'(busy), 32'd1);
      i2c_stop();
      wait_clk(2);
      check($sformatf("v%0d_busy_stop", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_oe_seen", i), 32'(oe_seen), 32'(vecs[i].acks != 3'b000));
      check($sformatf("v%0d_pulses", i), 32'(pulse_cnt - p0), 32'(vecs[i].pulse));
      if (vecs[i].pulse) begin
        check($sformatf("v%0d_waddr", i), 32'(reg_wr_addr), 32'(vecs[i].waddr));
        check($sformatf("v%0d_wdata", i), 32'(reg_wr_data), 32'(vecs[i].wdata));
      end
      check_reg($sformatf("v%0d_rd", i), vecs[i].ridx, vecs[i].rexp);
    end
    // After the reset-register write and the out-of-range write, all defaults
    for (int i = 0; i < 10; i++) check_reg($sformatf("post_tbl_reg%0d", i), 4'(i), defaults[i]);

    // Extra byte after a full frame is not acked, still one pulse
    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h34, ack0);
    send_byte(8'h08, ack1);
    send_byte(8'h21, ack2);
    send_byte(8'h55, ack);
    check("extra_acks", 32'({ack0, ack1, ack2}), 32'b111);
    check("extra_byte_ack", 32'(ack), 32'd0);
    check("extra_busy", 32'(busy), 32'd1);
    i2c_stop();
    wait_clk(2);
    check("extra_pulses", 32'(pulse_cnt - p0), 32'd1);
    check_reg("extra_r4", 4'd4, 9'h021);

    // Stop after byte1, then repeated start mid-byte2, then full write R0=0x117
    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h34, ack0);
    send_byte(8'h0A, ack1);
    i2c_stop();
    wait_clk(2);
    check("t5_stop_busy", 32'(busy), 32'd0);
    i2c_start();
    send_byte(8'h34, ack0);
    send_byte(8'h0A, ack1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_start();
    send_byte(8'h34, ack0);
    send_byte(8'h01, ack1);
    send_byte(8'h17, ack2);
    check("t5_acks", 32'({ack0, ack1, ack2}), 32'b111);
    i2c_stop();
    wait_clk(2);
    check("t5_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("t5_waddr", 32'(reg_wr_addr), 32'h00);
    check("t5_wdata", 32'(reg_wr_data), 32'h117);
    check_reg("t5_r0", 4'd0, 9'h117);
    check_reg("t5_r5", 4'd5, 9'h008);
    check_reg("t5_r4", 4'd4, 9'h021);

    // Reset pulse during the ack of byte1
    p0 = pulse_cnt;
    i2c_start();
    send_byte(8'h34, ack0);
    for (int i = 7; i >= 0; i--) send_bit(i == 2 || i == 3);
    sda_m = 1'b1; wait_clk(4);
    scl_m = 1'b1; wait_clk(4);
    check("t6_ack1_oe", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    check("t6_rst_oe", 32'(sda_oe), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check_reg("t6_rst_r0", 4'd0, 9'h097);
    check_reg("t6_rst_r4", 4'd4, 9'h00A);
    wait_clk(3);
    scl_m = 1'b0; wait_clk(4);
    i2c_stop();
    wait_clk(2);
    check("t6_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    i2c_start();
    send_byte(8'h34, ack0);
    send_byte(8'h08, ack1);
    send_byte(8'h33, ack2);
    check("t6_acks", 32'({ack0, ack1, ack2}), 32'b111);
    i2c_stop();
    wait_clk(2);
    check("t6_pulses", 32'(pulse_cnt - p0), 32'd1);
    check_reg("t6_r4", 4'd4, 9'h033);
    check_reg("t6_r0", 4'd0, 9'h097);

    check("single_cycle_pulses", 32'(dbl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
